// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks non-bypassable producers (long-latency results, load one
// stage ahead) and raises the ID stall/bubble so EX forwarding only ever sees forwardable data.
module hazard_scoreboard #(
   parameter int NUM_REGS        = 32,
   parameter int REG_ADDR_W      = 5,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_id_valid,
   input  logic [REG_ADDR_W-1:0] i_id_rs1,
   input  logic [REG_ADDR_W-1:0] i_id_rs2,
   input  logic                  i_id_uses_rs1,
   input  logic                  i_id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] i_id_rd,
   input  logic                  i_id_reg_write,
   input  logic                  i_id_long,
   input  logic                  i_id_is_load,
   input  logic                  i_hold,
   input  logic                  i_flush,
   input  logic                  i_long_done,
   input  logic [REG_ADDR_W-1:0] i_long_rd,
   output logic                  o_stall_id,
   output logic [NUM_REGS-1:0]   o_pending,
   output logic [1:0]            o_outstanding,
   output logic                  o_err
);

   localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

   logic                  ld_valid;
   logic [REG_ADDR_W-1:0] ld_rd;

   logic                  raw_long;
   logic                  load_use;
   logic                  waw;
   logic                  structural;
   logic                  issue;
   logic                  long_issue;
   logic                  set_en;
   logic                  done_bad;
   logic                  done_ok;
   logic                  load_capture;
   logic [NUM_REGS-1:0]   pending_nxt;

   assign raw_long   = (i_id_uses_rs1 && (i_id_rs1 != '0) && o_pending[i_id_rs1]) ||
                       (i_id_uses_rs2 && (i_id_rs2 != '0) && o_pending[i_id_rs2]);
   // Tracked rd is never x0, so a source of x0 can never match it.
   assign load_use   = ld_valid && ((i_id_uses_rs1 && (i_id_rs1 == ld_rd)) ||
                                    (i_id_uses_rs2 && (i_id_rs2 == ld_rd)));
   assign waw        = i_id_reg_write && (i_id_rd != '0) && o_pending[i_id_rd];
   assign structural = i_id_long && (o_outstanding == MAX_CNT);

   assign o_stall_id = i_id_valid && !i_flush && (raw_long || load_use || waw || structural);

   assign issue        = i_id_valid && !o_stall_id && !i_hold && !i_flush;
   assign long_issue   = issue && i_id_long;
   assign set_en       = long_issue && i_id_reg_write && (i_id_rd != '0);
   assign load_capture = issue && i_id_is_load && !i_id_long && (i_id_rd != '0);

   // A completion with no matching bookkeeping is a protocol error and changes no count.
   assign done_bad = i_long_done &&
                     (((i_long_rd != '0) && !o_pending[i_long_rd]) || (o_outstanding == 2'd0));
   assign done_ok  = i_long_done && !done_bad;

   always_comb begin
      // NOTE: default assignment first, so no path leaves pending_nxt unassigned (no latch).
      pending_nxt = o_pending;
      if (done_ok && (i_long_rd != '0)) pending_nxt[i_long_rd] = 1'b0;
      // Set is applied after clear so a same-index set/clear leaves the bit set.
      if (set_en) pending_nxt[i_id_rd] = 1'b1;
   end

   // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_pending     <= '0;
         o_outstanding <= 2'd0;
         o_err         <= 1'b0;
         ld_valid      <= 1'b0;
         ld_rd         <= '0;
      end else begin
         o_pending <= pending_nxt;

         if (long_issue && !done_ok)      o_outstanding <= o_outstanding + 2'd1;
         else if (!long_issue && done_ok) o_outstanding <= o_outstanding - 2'd1;

         if (done_bad) o_err <= 1'b1;

         if (i_flush) begin
            ld_valid <= 1'b0;
         end else if (load_capture) begin
            ld_valid <= 1'b1;
            ld_rd    <= i_id_rd;
         end else if (!i_hold) begin
            ld_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scenario bench for hazard_scoreboard: each row pushes its expected outputs when driven,
// and the entry is popped and compared at the following negative edge.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_id_valid;
   logic [4:0]  i_id_rs1;
   logic [4:0]  i_id_rs2;
   logic        i_id_uses_rs1;
   logic        i_id_uses_rs2;
   logic [4:0]  i_id_rd;
   logic        i_id_reg_write;
   logic        i_id_long;
   logic        i_id_is_load;
   logic        i_hold;
   logic        i_flush;
   logic        i_long_done;
   logic [4:0]  i_long_rd;
   logic        o_stall_id;
   logic [31:0] o_pending;
   logic [1:0]  o_outstanding;
   logic        o_err;

   always #5 clk = ~clk;

   hazard_scoreboard #(
      .NUM_REGS        (32),
      .REG_ADDR_W      (5),
      .MAX_OUTSTANDING (2)
   ) dut (
      .i_clk          (clk),
      .i_rst          (i_rst),
      .i_id_valid     (i_id_valid),
      .i_id_rs1       (i_id_rs1),
      .i_id_rs2       (i_id_rs2),
      .i_id_uses_rs1  (i_id_uses_rs1),
      .i_id_uses_rs2  (i_id_uses_rs2),
      .i_id_rd        (i_id_rd),
      .i_id_reg_write (i_id_reg_write),
      .i_id_long      (i_id_long),
      .i_id_is_load   (i_id_is_load),
      .i_hold         (i_hold),
      .i_flush        (i_flush),
      .i_long_done    (i_long_done),
      .i_long_rd      (i_long_rd),
      .o_stall_id     (o_stall_id),
      .o_pending      (o_pending),
      .o_outstanding  (o_outstanding),
      .o_err          (o_err)
   );

   typedef struct packed {
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       we;
      logic       lng;
      logic       ld;
   } instr_t;

   typedef struct {
      instr_t      in;
      logic        hold;
      logic        flush;
      logic        done;
      logic [4:0]  drd;
      logic [35:0] want;   // {stall, pending[31:0], outstanding[1:0], err}
   } row_t;

   logic [35:0] exp_q[$];
   int          total = 0;
   int          bad   = 0;

   function automatic instr_t nop();
      return '0;
   endfunction

   function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return instr_t'{v:1'b1, rs1:rs1, u1:1'b1, rs2:rs2, u2:1'b1, rd:rd, we:1'b1, lng:1'b0, ld:1'b0};
   endfunction

   function automatic instr_t load(input logic [4:0] rd, input logic [4:0] rs1);
      return instr_t'{v:1'b1, rs1:rs1, u1:1'b1, rs2:5'd0, u2:1'b0, rd:rd, we:1'b1, lng:1'b0, ld:1'b1};
   endfunction

   function automatic instr_t lop(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic we);
      return instr_t'{v:1'b1, rs1:rs1, u1:1'b1, rs2:rs2, u2:1'b1, rd:rd, we:we, lng:1'b1, ld:1'b0};
   endfunction

   function automatic logic [31:0] b(input int r);
      return 32'd1 << r;
   endfunction

   function automatic row_t mk(input instr_t in, input logic s, input logic [31:0] p,
                               input logic [1:0] o, input logic e,
                               input logic hold = 1'b0, input logic flush = 1'b0,
                               input logic done = 1'b0, input logic [4:0] drd = 5'd0);
      row_t r;
      r.in = in; r.hold = hold; r.flush = flush; r.done = done; r.drd = drd;
      r.want = {s, p, o, e};
      return r;
   endfunction

   function automatic logic [35:0] obs();
      return {o_stall_id, o_pending, o_outstanding, o_err};
   endfunction

   task automatic apply(input row_t r);
      i_id_valid     = r.in.v;
      i_id_rs1       = r.in.rs1;
      i_id_uses_rs1  = r.in.u1;
      i_id_rs2       = r.in.rs2;
      i_id_uses_rs2  = r.in.u2;
      i_id_rd        = r.in.rd;
      i_id_reg_write = r.in.we;
      i_id_long      = r.in.lng;
      i_id_is_load   = r.in.ld;
      i_hold         = r.hold;
      i_flush        = r.flush;
      i_long_done    = r.done;
      i_long_rd      = r.drd;
      exp_q.push_back(r.want);
   endtask

   task automatic test_reset();
      logic [35:0] want;
      i_rst = 1'b1;
      apply(mk(nop(), 0, 32'd0, 2'd0, 0));
      @(negedge clk);
      want = exp_q.pop_front();
      total++;
      if (obs() !== want) begin
         bad++;
         $display("FAIL reset: got {stall,pend,out,err}=%h want %h", obs(), want);
      end
      @(posedge clk); #1;
      i_rst = 1'b0;
   endtask

   task automatic test_load_use();
      row_t rows[$];
      logic [35:0] want;
      rows.push_back(mk(load(5, 1),    0, 32'd0, 2'd0, 0));
      rows.push_back(mk(alu(6, 5, 1),  1, 32'd0, 2'd0, 0));   // one bubble
      rows.push_back(mk(alu(6, 5, 1),  0, 32'd0, 2'd0, 0));
      rows.push_back(mk(load(8, 1),    0, 32'd0, 2'd0, 0));
      rows.push_back(mk(alu(9, 1, 8),  1, 32'd0, 2'd0, 0));   // rs2 dependency
      rows.push_back(mk(alu(9, 1, 8),  0, 32'd0, 2'd0, 0));
      rows.push_back(mk(load(5, 1),    0, 32'd0, 2'd0, 0));
      rows.push_back(mk(alu(6, 1, 2),  0, 32'd0, 2'd0, 0));   // independent
      rows.push_back(mk(load(0, 1),    0, 32'd0, 2'd0, 0));   // load to x0 not tracked
      rows.push_back(mk(alu(6, 0, 0),  0, 32'd0, 2'd0, 0));
      rows.push_back(mk(nop(),         0, 32'd0, 2'd0, 0));
      foreach (rows[i]) begin
         @(posedge clk); #1;
         apply(rows[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         total++;
         if (obs() !== want) begin
            bad++;
            $display("FAIL load_use row %0d: got {stall,pend,out,err}=%h want %h", i, obs(), want);
         end
      end
   endtask

   task automatic test_raw_long();
      row_t rows[$];
      logic [35:0] want;
      rows.push_back(mk(lop(7, 1, 2, 1), 0, 32'd0, 2'd0, 0));
      for (int k = 1; k <= 9; k++) rows.push_back(mk(alu(8, 7, 1), 1, b(7), 2'd1, 0));
      rows.push_back(mk(alu(8, 7, 1), 1, b(7), 2'd1, 0, 0, 0, 1, 5'd7));   // done in cycle 10
      rows.push_back(mk(alu(8, 7, 1), 0, 32'd0, 2'd0, 0));                 // issues in 11
      rows.push_back(mk(nop(),        0, 32'd0, 2'd0, 0));
      foreach (rows[i]) begin
         @(posedge clk); #1;
         apply(rows[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         total++;
         if (obs() !== want) begin
            bad++;
            $display("FAIL raw_long row %0d: got {stall,pend,out,err}=%h want %h", i, obs(), want);
         end
      end
   endtask

   task automatic test_structural();
      row_t rows[$];
      logic [35:0] want;
      rows.push_back(mk(lop(3, 1, 2, 1),  0, 32'd0,             2'd0, 0));
      rows.push_back(mk(lop(4, 1, 2, 1),  0, b(3),              2'd1, 0));
      rows.push_back(mk(lop(10, 1, 2, 1), 1, b(3) | b(4),       2'd2, 0));
      rows.push_back(mk(lop(10, 1, 2, 1), 1, b(3) | b(4),       2'd2, 0, 0, 0, 1, 5'd3));
      rows.push_back(mk(lop(10, 1, 2, 1), 0, b(4),              2'd1, 0));
      rows.push_back(mk(nop(),            0, b(4) | b(10),      2'd2, 0, 0, 0, 1, 5'd4));
      rows.push_back(mk(lop(11, 1, 2, 1), 0, b(10),             2'd1, 0, 0, 0, 1, 5'd10));
      rows.push_back(mk(nop(),            0, b(11),             2'd1, 0, 0, 0, 1, 5'd11));
      rows.push_back(mk(nop(),            0, 32'd0,             2'd0, 0));
      foreach (rows[i]) begin
         @(posedge clk); #1;
         apply(rows[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         total++;
         if (obs() !== want) begin
            bad++;
            $display("FAIL structural row %0d: got {stall,pend,out,err}=%h want %h", i, obs(), want);
         end
      end
   endtask

   task automatic test_waw();
      row_t rows[$];
      logic [35:0] want;
      rows.push_back(mk(lop(3, 1, 2, 1),  0, 32'd0, 2'd0, 0));
      rows.push_back(mk(alu(3, 1, 2),     1, b(3),  2'd1, 0));
      rows.push_back(mk(alu(3, 1, 2),     1, b(3),  2'd1, 0, 0, 0, 1, 5'd3));
      rows.push_back(mk(alu(3, 1, 2),     0, 32'd0, 2'd0, 0));
      rows.push_back(mk(lop(0, 0, 0, 1),  0, 32'd0, 2'd0, 0));   // long to x0: counted, no bit
      rows.push_back(mk(lop(12, 1, 2, 0), 0, 32'd0, 2'd1, 0));   // long without reg write
      rows.push_back(mk(alu(0, 0, 0),     0, 32'd0, 2'd2, 0));
      rows.push_back(mk(nop(),            0, 32'd0, 2'd2, 0, 0, 0, 1, 5'd0));
      rows.push_back(mk(nop(),            0, 32'd0, 2'd1, 0, 0, 0, 1, 5'd0));
      rows.push_back(mk(nop(),            0, 32'd0, 2'd0, 0));
      foreach (rows[i]) begin
         @(posedge clk); #1;
         apply(rows[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         total++;
         if (obs() !== want) begin
            bad++;
            $display("FAIL waw row %0d: got {stall,pend,out,err}=%h want %h", i, obs(), want);
         end
      end
   endtask

   task automatic test_flush_hold();
      row_t rows[$];
      logic [35:0] want;
      rows.push_back(mk(load(5, 1),      0, 32'd0, 2'd0, 0));
      rows.push_back(mk(alu(6, 5, 1),    1, 32'd0, 2'd0, 0, 1));      // hold keeps tracker
      rows.push_back(mk(alu(6, 5, 1),    1, 32'd0, 2'd0, 0, 1));
      rows.push_back(mk(alu(6, 5, 1),    1, 32'd0, 2'd0, 0));
      rows.push_back(mk(alu(6, 5, 1),    0, 32'd0, 2'd0, 0));
      rows.push_back(mk(load(5, 1),      0, 32'd0, 2'd0, 0));
      rows.push_back(mk(alu(6, 5, 1),    0, 32'd0, 2'd0, 0, 1, 1));   // flush clears tracker
      rows.push_back(mk(alu(6, 5, 1),    0, 32'd0, 2'd0, 0, 1));
      rows.push_back(mk(lop(7, 1, 2, 1), 0, 32'd0, 2'd0, 0));
      rows.push_back(mk(nop(),           0, b(7),  2'd1, 0, 0, 1));
      rows.push_back(mk(alu(8, 7, 1),    0, b(7),  2'd1, 0, 0, 1));   // flush forces stall low
      rows.push_back(mk(nop(),           0, b(7),  2'd1, 0, 0, 0, 1, 5'd7));
      rows.push_back(mk(nop(),           0, 32'd0, 2'd0, 0));
      foreach (rows[i]) begin
         @(posedge clk); #1;
         apply(rows[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         total++;
         if (obs() !== want) begin
            bad++;
            $display("FAIL flush_hold row %0d: got {stall,pend,out,err}=%h want %h", i, obs(), want);
         end
      end
   endtask

   task automatic test_err();
      row_t rows[$];
      logic [35:0] want;
      rows.push_back(mk(lop(3, 1, 2, 1), 0, 32'd0, 2'd0, 0));
      rows.push_back(mk(nop(),           0, b(3),  2'd1, 0, 0, 0, 1, 5'd9));   // x9 not pending
      rows.push_back(mk(nop(),           0, b(3),  2'd1, 1));
      rows.push_back(mk(nop(),           0, b(3),  2'd1, 1, 0, 0, 1, 5'd3));
      rows.push_back(mk(nop(),           0, 32'd0, 2'd0, 1));
      rows.push_back(mk(nop(),           0, 32'd0, 2'd0, 1, 0, 0, 1, 5'd0));   // count already 0
      rows.push_back(mk(nop(),           0, 32'd0, 2'd0, 1));
      foreach (rows[i]) begin
         @(posedge clk); #1;
         apply(rows[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         total++;
         if (obs() !== want) begin
            bad++;
            $display("FAIL err row %0d: got {stall,pend,out,err}=%h want %h", i, obs(), want);
         end
      end
   endtask

   task automatic test_reset_mid();
      row_t rows[$];
      row_t post[$];
      logic [35:0] want;
      rows.push_back(mk(lop(3, 1, 2, 1), 0, 32'd0, 2'd0, 1));
      rows.push_back(mk(nop(),           0, b(3),  2'd1, 1));
      foreach (rows[i]) begin
         @(posedge clk); #1;
         apply(rows[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         total++;
         if (obs() !== want) begin
            bad++;
            $display("FAIL reset_mid row %0d: got {stall,pend,out,err}=%h want %h", i, obs(), want);
         end
      end
      // Asynchronous: state must clear between clock edges.
      #2;
      i_rst = 1'b1;
      exp_q.push_back(36'd0);
      #1;
      want = exp_q.pop_front();
      total++;
      if (obs() !== want) begin
         bad++;
         $display("FAIL reset_async: got {stall,pend,out,err}=%h want %h", obs(), want);
      end
      @(posedge clk); #1;
      i_rst = 1'b0;
      post.push_back(mk(nop(), 0, 32'd0, 2'd0, 0, 0, 0, 1, 5'd3));   // stale completion
      post.push_back(mk(nop(), 0, 32'd0, 2'd0, 1));
      post.push_back(mk(nop(), 0, 32'd0, 2'd0, 1));
      foreach (post[i]) begin
         @(posedge clk); #1;
         apply(post[i]);
         @(negedge clk);
         want = exp_q.pop_front();
         total++;
         if (obs() !== want) begin
            bad++;
            $display("FAIL reset_post row %0d: got {stall,pend,out,err}=%h want %h", i, obs(), want);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      apply(mk(nop(), 0, 32'd0, 2'd0, 0));
      void'(exp_q.pop_front());
      test_reset();
      test_load_use();
      test_raw_long();
      test_structural();
      test_waw();
      test_flush_hold();
      test_err();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
